uart_top: RTL and testbench
===========================

Name: uart_top

Overview:
- 8N1 UART with a transmit FIFO and a receive FIFO.
- The host side writes bytes into the TX FIFO; the transmitter serializes them onto `tx`.
- The receiver deserializes `rx` into the RX FIFO; the host reads bytes from there.
- Sits behind the uart_top_if DUT modport as the top-level UART block.

Parameters:
- DATA_WIDTH, 8, bits per character and FIFO word width.
- FIFO_DEPTH, 16, entries per FIFO; must be a power of two.
- CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_din  in  DATA_WIDTH  byte to enqueue in the TX FIFO.
- wr_uart  in  1  push tx_din into the TX FIFO this cycle.
- rd_uart  in  1  pop the RX FIFO head this cycle.
- rx  in  1  serial input, asynchronous, idle high.
- tx  out  1  serial output, idle high.
- rx_dout  out  DATA_WIDTH  RX FIFO head, first-word-fall-through.
- tx_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- rx_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- tx_fifo_empty  out  1  tx_fifo_cnt==0.
- tx_fifo_full  out  1  tx_fifo_cnt==FIFO_DEPTH.
- rx_fifo_empty  out  1  rx_fifo_cnt==0.
- rx_fifo_full  out  1  rx_fifo_cnt==FIFO_DEPTH.

Behaviour:
- Reset (rst=1 at a clk edge) applies in every state, including mid-frame:
  - tx=1, both counts 0, both empty=1, both full=0, rx_dout=0.
  - FIFO pointers cleared; TX and RX FSMs return to IDLE; any partial frame is discarded.
- FIFOs (two identical instances):
  - Circular buffer with wrap-around pointers; count register.
  - Flags and counts are combinational from the count register.
  - Push when full is ignored; pop when empty is ignored.
  - Simultaneous push+pop when 0<cnt<FIFO_DEPTH: both happen, count unchanged.
  - Simultaneous push+pop when full: both happen, count stays FIFO_DEPTH.
  - Simultaneous push+pop when empty: push only.
  - Read is first-word-fall-through: head data is valid whenever not empty.
  - rx_dout = RX FIFO head when not empty, 0 when empty.
  - A pushed word is visible on rx_dout the cycle after the push edge.
- Host TX side: wr_uart && !tx_fifo_full pushes tx_din; tx_fifo_cnt increments at that edge.
- Transmitter FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If !tx_fifo_empty, pop the head into the shift register and go to START; tx falls on the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Frame is 10*CLKS_PER_BIT cycles; back-to-back frames are separated by one IDLE cycle.
- Receiver:
  - rx passes through a 2-flop synchronizer.
  - FSM states IDLE, START, DATA, STOP.
  - IDLE: a 1->0 transition on the synchronized rx enters START.
  - START: samples at CLKS_PER_BIT/2. If rx is high (glitch) → IDLE, else continue.
  - DATA: samples each bit every CLKS_PER_BIT cycles after that point (mid-bit), shifting in LSB first.
  - STOP: samples mid stop bit.
    - If stop=1 and !rx_fifo_full: push the byte into the RX FIFO; rx_fifo_cnt increments at that edge.
    - If stop=0 (framing error) or the RX FIFO is full: drop the byte silently.
    - Either way, return to IDLE right after the stop-bit sample (early re-arm for the next start edge).
- Host RX side: rd_uart && !rx_fifo_empty pops; rx_dout shows the next entry (or 0) the following cycle.
- Receiver push and host pop in the same cycle follow the simultaneous-push/pop rules above.
- The TX and RX paths are fully independent and may run concurrently.

Test Plan:
- Reset: assert rst 2 cycles mid-transmission → tx=1, counts 0, tx/rx_fifo_empty=1, full flags 0, rx_dout=0.
- Single TX: write 0xA5 → tx_fifo_cnt 1 then 0 when popped.
  - tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1 (16 cycles each), then high for 16 cycles.
- Loopback (rx tied to tx): write 0x3C, 0xFF, 0x00 back-to-back.
  - After 3 frames (~480+ cycles): rx_fifo_cnt=3, rx_dout=0x3C.
  - rd_uart pops yield 0xFF, then 0x00; rx_fifo_empty=1, rx_dout=0 after the last pop.
- TX full: with rx idle, issue 17+ consecutive wr_uart cycles (TX busy).
  - tx_fifo_full asserts at cnt=16; the extra write is ignored; count never exceeds 16.
- RX overflow: drive 17 valid frames on rx without reads.
  - rx_fifo_cnt=16, rx_fifo_full=1, 17th byte dropped, rx_dout = first byte.
- Errors: rx low for 4 cycles then high → no push. Frame with stop bit 0 → no push, cnt unchanged.
- Concurrency: pop on empty RX FIFO → no change. Simultaneous receiver push and host pop at cnt=2 → cnt stays 2.

Source files
------------

// File: rtl/uart_top.sv
// 8N1 UART: host-facing TX/RX FIFOs around a bit-serial transmitter and receiver.
// Bit timing comes from down-counters reloaded to CLKS_PER_BIT-1 and compared against zero.

module uart_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_WIDTH-1:0]         din,
   output logic [DATA_WIDTH-1:0]         head,
   output logic [$clog2(FIFO_DEPTH):0]   cnt,
   output logic                          empty,
   output logic                          full
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           cnt_q, cnt_d;
   logic                  do_push, do_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign cnt   = cnt_q;
   assign head  = mem_q[rd_ptr_q];

   // A pop frees the slot in the same edge, so push-while-full succeeds only alongside a pop.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// state | meaning
// IDLE  | line high, waiting for a byte in the TX FIFO
// START | driving the start bit (low)
// DATA  | shifting out data bits, LSB first
// STOP  | driving the stop bit (high)
module uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_head,
   output logic                  fifo_pop,
   output logic                  tx
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t             state_q, state_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  tmr_done;

   assign tx = tx_q;

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      tmr_done = (tmr_q == '0);
      case (state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_head;
               tmr_d    = TMR_LOAD;
               state_d  = TX_START;
            end
         end
         TX_START: begin
            if (tmr_done) begin
               tmr_d   = TMR_LOAD;
               bit_d   = '0;
               state_d = TX_DATA;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         TX_DATA: begin
            if (tmr_done) begin
               tmr_d   = TMR_LOAD;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  state_d = TX_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         TX_STOP: begin
            if (tmr_done) begin
               state_d = TX_IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = TX_IDLE;
      endcase
      // Line level is registered from the next state so tx never glitches.
      case (state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TX_IDLE;
         tmr_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end
endmodule

// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronized line
// START | counting to mid start bit; high there means a glitch
// DATA  | sampling data bits mid-bit, LSB first
// STOP  | sampling the stop bit; push on a good frame, then re-arm
module uart_rx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  fifo_full,
   output logic                  push,
   output logic [DATA_WIDTH-1:0] data
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TMR_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t             state_q, state_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  rx_s1_q, rx_s1_d;
   logic                  rx_s2_q, rx_s2_d;
   logic                  rx_prev_q, rx_prev_d;
   logic                  tmr_done;

   assign data = shift_q;

   always_comb begin
      rx_s1_d   = rx;
      rx_s2_d   = rx_s1_q;
      rx_prev_d = rx_s2_q;
      state_d   = state_q;
      tmr_d     = tmr_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      tmr_done  = (tmr_q == '0);
      case (state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               tmr_d   = TMR_HALF;
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (tmr_done) begin
               if (rx_s2_q) begin
                  state_d = RX_IDLE;
               end else begin
                  tmr_d   = TMR_LOAD;
                  bit_d   = '0;
                  state_d = RX_DATA;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         RX_DATA: begin
            if (tmr_done) begin
               tmr_d   = TMR_LOAD;
               shift_d = {rx_s2_q, shift_q[DATA_WIDTH-1:1]};
               if (bit_q == BIT_LAST) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         RX_STOP: begin
            if (tmr_done) begin
               push    = rx_s2_q && !fifo_full;
               state_d = RX_IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RX_IDLE;
         tmr_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_s1_q   <= rx_s1_d;
         rx_s2_q   <= rx_s2_d;
         rx_prev_q <= rx_prev_d;
      end
   end
endmodule

module uart_top #(
   parameter int DATA_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        tx_din,
   input  logic                         wr_uart,
   input  logic                         rd_uart,
   input  logic                         rx,
   output logic                         tx,
   output logic [DATA_WIDTH-1:0]        rx_dout,
   output logic [$clog2(FIFO_DEPTH):0]  tx_fifo_cnt,
   output logic [$clog2(FIFO_DEPTH):0]  rx_fifo_cnt,
   output logic                         tx_fifo_empty,
   output logic                         tx_fifo_full,
   output logic                         rx_fifo_empty,
   output logic                         rx_fifo_full
);
   logic [DATA_WIDTH-1:0] tx_head, rx_head, rx_data;
   logic                  tx_pop, rx_push, tx_push;

   // Host writes never displace data, even when the transmitter pops in the same cycle.
   assign tx_push = wr_uart && !tx_fifo_full;
   assign rx_dout = rx_fifo_empty ? '0 : rx_head;

   uart_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (tx_din),
      .head  (tx_head),
      .cnt   (tx_fifo_cnt),
      .empty (tx_fifo_empty),
      .full  (tx_fifo_full)
   );

   uart_tx #(.DATA_WIDTH(DATA_WIDTH), .CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (tx_fifo_empty),
      .fifo_head  (tx_head),
      .fifo_pop   (tx_pop),
      .tx         (tx)
   );

   uart_rx #(.DATA_WIDTH(DATA_WIDTH), .CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .fifo_full (rx_fifo_full),
      .push      (rx_push),
      .data      (rx_data)
   );

   uart_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rd_uart),
      .din   (rx_data),
      .head  (rx_head),
      .cnt   (rx_fifo_cnt),
      .empty (rx_fifo_empty),
      .full  (rx_fifo_full)
   );
endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: table-driven RX frames, scoreboard of expected RX bytes,
// plus hand-written TX timing, loopback, overflow, reset and concurrency sequences.

module tb_uart_top;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CPB   = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] tx_din = '0;
   logic          wr_uart = 1'b0;
   logic          rd_uart = 1'b0;
   logic          rx_drv = 1'b1;
   logic          loopback = 1'b0;
   logic          rx_line;
   logic          tx;
   logic [DW-1:0] rx_dout;
   logic [CW-1:0] tx_fifo_cnt, rx_fifo_cnt;
   logic          tx_fifo_empty, tx_fifo_full, rx_fifo_empty, rx_fifo_full;

   always_comb rx_line = loopback ? tx : rx_drv;
   always #5 clk = ~clk;

   uart_top #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_din        (tx_din),
      .wr_uart       (wr_uart),
      .rd_uart       (rd_uart),
      .rx            (rx_line),
      .tx            (tx),
      .rx_dout       (rx_dout),
      .tx_fifo_cnt   (tx_fifo_cnt),
      .rx_fifo_cnt   (rx_fifo_cnt),
      .tx_fifo_empty (tx_fifo_empty),
      .tx_fifo_full  (tx_fifo_full),
      .rx_fifo_empty (rx_fifo_empty),
      .rx_fifo_full  (rx_fifo_full)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          stop_b;
      logic          glitch;
      logic          exp_push;
   } rx_vec_t;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] sb[$];
   int            push_seen;
   int            push_k;
   int            model_cnt;
   int            n;
   int            low_len;
   int            max_cnt;
   rx_vec_t       vecs[6];
   logic [9:0]    a5_bits;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " tx"}, tx, 1);
      check({tag, " tx_cnt"}, tx_fifo_cnt, 0);
      check({tag, " rx_cnt"}, rx_fifo_cnt, 0);
      check({tag, " tx_empty"}, tx_fifo_empty, 1);
      check({tag, " rx_empty"}, rx_fifo_empty, 1);
      check({tag, " tx_full"}, tx_fifo_full, 0);
      check({tag, " rx_full"}, rx_fifo_full, 0);
      check({tag, " rx_dout"}, rx_dout, 0);
   endtask

   // Called at a negedge: compare the FWFT head with the scoreboard, then pop for one edge.
   task automatic host_read(input string name);
      logic [DW-1:0] exp;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got %0h expected no data (scoreboard empty)", name, rx_dout);
      end else begin
         exp = sb.pop_front();
         check(name, rx_dout, exp);
      end
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
   endtask

   // Drives one 8N1 frame plus two idle bit times; records the negedge index whose
   // following posedge pushed into the RX FIFO, and optionally pops on index pop_at.
   task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input int pop_at);
      logic [9:0]    bits;
      logic [CW-1:0] prev;
      bits      = {stop_b, d, 1'b0};
      prev      = rx_fifo_cnt;
      push_seen = -1;
      for (int i = 0; i < 12 * CPB; i++) begin
         rx_drv  = (i < 10 * CPB) ? bits[i / CPB] : 1'b1;
         rd_uart = (i == pop_at);
         @(negedge clk);
         if (push_seen < 0 && rx_fifo_cnt > prev) push_seen = i;
         prev = rx_fifo_cnt;
      end
      rd_uart = 1'b0;
      rx_drv  = 1'b1;
   endtask

   initial begin
      vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{8'h81, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{8'h7E, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'hC3, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1};

      // Reset values
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single TX frame 0xA5
      tx_din  = 8'hA5;
      wr_uart = 1'b1;
      @(negedge clk);
      wr_uart = 1'b0;
      check("tx cnt after write", tx_fifo_cnt, 1);
      check("tx idle after write", tx, 1);
      n = 0;
      while (tx !== 1'b0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("tx start edge seen", (n < 8), 1);
      check("tx cnt after pop", tx_fifo_cnt, 0);
      low_len = 0;
      while (tx === 1'b0 && low_len < 40) begin
         low_len++;
         @(negedge clk);
      end
      check("tx start bit length", low_len, CPB);
      a5_bits = {1'b1, 8'hA5, 1'b0};
      for (int b = 1; b < 10; b++) begin
         repeat (CPB / 2) @(negedge clk);
         check($sformatf("tx bit %0d", b), tx, a5_bits[b]);
         repeat (CPB / 2) @(negedge clk);
      end

      // Reset mid-transmission
      tx_din  = 8'h5A;
      wr_uart = 1'b1;
      @(negedge clk);
      tx_din = 8'h96;
      @(negedge clk);
      wr_uart = 1'b0;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_state("mid-frame reset");
      repeat (20) @(negedge clk);
      check("tx idle after reset", tx, 1);
      check("tx fifo empty after reset", tx_fifo_empty, 1);

      // Loopback of three back-to-back bytes
      loopback = 1'b1;
      wr_uart  = 1'b1;
      tx_din = 8'h3C; sb.push_back(8'h3C); @(negedge clk);
      tx_din = 8'hFF; sb.push_back(8'hFF); @(negedge clk);
      tx_din = 8'h00; sb.push_back(8'h00); @(negedge clk);
      wr_uart = 1'b0;
      n = 0;
      while (rx_fifo_cnt != 3 && n < 800) begin
         @(negedge clk);
         n++;
      end
      check("loopback frames arrived", (n < 800), 1);
      check("loopback rx cnt", rx_fifo_cnt, 3);
      host_read("loopback byte 0");
      host_read("loopback byte 1");
      host_read("loopback byte 2");
      check("loopback rx empty", rx_fifo_empty, 1);
      check("loopback rx_dout zero", rx_dout, 0);
      repeat (20) @(negedge clk);
      loopback = 1'b0;
      repeat (4) @(negedge clk);

      // Table of RX frames: good, framing error, glitch
      model_cnt = 0;
      push_k    = -1;
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].glitch) begin
            rx_drv = 1'b0;
            repeat (4) @(negedge clk);
            rx_drv = 1'b1;
            repeat (3 * CPB) @(negedge clk);
         end else begin
            send_frame(vecs[i].data, vecs[i].stop_b, -1);
            if (i == 0) push_k = push_seen;
         end
         if (vecs[i].exp_push) begin
            model_cnt++;
            sb.push_back(vecs[i].data);
         end
         check($sformatf("rx vec %0d cnt", i), rx_fifo_cnt, model_cnt);
      end
      check("rx push timing found", (push_k >= 0), 1);
      for (int i = 0; i < 4; i++) host_read($sformatf("rx vec read %0d", i));
      check("rx drained empty", rx_fifo_empty, 1);
      check("rx drained dout", rx_dout, 0);

      // Pop on empty RX FIFO
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
      check("pop empty cnt", rx_fifo_cnt, 0);
      check("pop empty flag", rx_fifo_empty, 1);
      check("pop empty dout", rx_dout, 0);

      // Receiver push and host pop on the same edge at cnt=2
      send_frame(8'h11, 1'b1, -1); sb.push_back(8'h11);
      send_frame(8'h22, 1'b1, -1); sb.push_back(8'h22);
      check("concurrency pre cnt", rx_fifo_cnt, 2);
      check("concurrency head", rx_dout, sb.pop_front());
      send_frame(8'h33, 1'b1, push_k); sb.push_back(8'h33);
      check("concurrency cnt stays 2", rx_fifo_cnt, 2);
      host_read("concurrency read 0");
      host_read("concurrency read 1");
      check("concurrency empty", rx_fifo_empty, 1);

      // RX overflow: 17 frames, no reads
      for (int i = 0; i < 17; i++) begin
         send_frame(DW'(8'h60 + i), 1'b1, -1);
         if (i < 16) sb.push_back(DW'(8'h60 + i));
      end
      check("overflow cnt", rx_fifo_cnt, 16);
      check("overflow full", rx_fifo_full, 1);
      for (int i = 0; i < 16; i++) host_read($sformatf("overflow read %0d", i));
      check("overflow drained empty", rx_fifo_empty, 1);
      check("overflow drained dout", rx_dout, 0);

      // TX full while transmitter busy
      max_cnt = 0;
      wr_uart = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tx_din = DW'(i);
         @(negedge clk);
         if (int'(tx_fifo_cnt) > max_cnt) max_cnt = int'(tx_fifo_cnt);
      end
      wr_uart = 1'b0;
      check("tx full cnt", tx_fifo_cnt, 16);
      check("tx full flag", tx_fifo_full, 1);
      check("tx max cnt", max_cnt, 16);
      n = 0;
      while (tx_fifo_cnt == 16 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tx drain started", (n < 200), 1);
      check("tx cnt after next pop", tx_fifo_cnt, 15);
      check("tx full cleared", tx_fifo_full, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish by time limit, expected finish");
      $fatal(1);
   end
endmodule
